// File: rtl/serial_io_pkg.sv
// Shared register map, STATUS bit positions and counter widths for serial_io_ctrl.
package serial_io_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_TXCOUNT = 2'd2,
    REG_RSVD    = 2'd3
  } reg_off_e;

  localparam int ST_RX_FULL  = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_CNT_LSB  = 8;
  localparam int ST_CNT_W    = 3;

  localparam int TXCNT_W = 16;

endpackage

// File: rtl/serial_io_ctrl_tx_fifo.sv
// Byte FIFO for the TX path; power-of-two depth so pointers wrap naturally.
module serial_tx_fifo #(
  parameter int TX_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(TX_DEPTH):0]  count
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;

  logic [TX_DEPTH-1:0][7:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic                     do_push, do_pop;

  assign full    = (count == CW'(TX_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/serial_io_ctrl.sv
// Memory-mapped serial port controller: TX FIFO drain, one-entry RX holder, store stall.
module serial_io_ctrl
  import serial_io_pkg::*;
#(
  parameter int          TX_DEPTH  = 4,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_wren,
  input  logic        cpu_rden,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic [7:0]  serial_in,
  input  logic        serial_valid_in,
  input  logic        serial_ready_in,
  output logic        serial_rden_out,
  output logic [7:0]  serial_out,
  output logic        serial_wren_out
);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic               hit, data_wr, data_rd;
  reg_off_e           off;
  logic               tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]         tx_head;
  logic [CW-1:0]      tx_count;
  logic               rx_full;
  logic [7:0]         rx_data;
  logic [TXCNT_W-1:0] txcount;
  logic [31:0]        status;

  assign hit     = (cpu_addr[31:4] == BASE_ADDR[31:4]);
  assign off     = reg_off_e'(cpu_addr[3:2]);
  assign data_wr = hit & cpu_wren & (off == REG_DATA);
  assign data_rd = hit & cpu_rden & (off == REG_DATA);

  // Full is the pre-edge state, so a store stalls even when a pop frees a slot this cycle.
  assign cpu_stall       = ~reset & data_wr & tx_full;
  assign tx_push         = data_wr & ~tx_full;
  assign tx_pop          = ~tx_empty & serial_ready_in;
  assign serial_rden_out = ~reset & serial_valid_in & ~rx_full;

  serial_tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (cpu_wdata[7:0]),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      serial_out      <= '0;
      serial_wren_out <= 1'b0;
      txcount         <= '0;
    end else begin
      serial_wren_out <= tx_pop;
      if (tx_pop) begin
        serial_out <= tx_head;
        txcount    <= txcount + 1'b1;
      end
    end
  end

  // A clearing read blocks capture this cycle because rden_out is gated by pre-edge rx_full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_full <= 1'b0;
      rx_data <= '0;
    end else if (data_rd && rx_full) begin
      rx_full <= 1'b0;
    end else if (serial_rden_out) begin
      rx_full <= 1'b1;
      rx_data <= serial_in;
    end
  end

  always_comb begin
    status                         = '0;
    status[ST_RX_FULL]             = rx_full;
    status[ST_TX_FULL]             = tx_full;
    status[ST_TX_EMPTY]            = tx_empty;
    status[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(tx_count);
  end

  always_comb begin
    cpu_rdata = '0;
    if (hit && cpu_rden) begin
      case (off)
        REG_DATA:    cpu_rdata = rx_full ? {24'd0, rx_data} : 32'd0;
        REG_STATUS:  cpu_rdata = status;
        REG_TXCOUNT: cpu_rdata = 32'(txcount);
        default:     cpu_rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_io_ctrl.sv
// Bench for serial_io_ctrl: queue-based reference model compared every cycle, plus directed literals.
module tb_serial_io_ctrl;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hFFFF0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_wren, cpu_rden, cpu_stall;
  logic [7:0]  serial_in, serial_out;
  logic        serial_valid_in, serial_ready_in, serial_rden_out, serial_wren_out;

  serial_io_ctrl #(.TX_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_wren        (cpu_wren),
    .cpu_rden        (cpu_rden),
    .cpu_rdata       (cpu_rdata),
    .cpu_stall       (cpu_stall),
    .serial_in       (serial_in),
    .serial_valid_in (serial_valid_in),
    .serial_ready_in (serial_ready_in),
    .serial_rden_out (serial_rden_out),
    .serial_out      (serial_out),
    .serial_wren_out (serial_wren_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  q[$];
  logic        m_rx_full;
  logic [7:0]  m_rx_data;
  logic [15:0] m_txcnt;
  logic [7:0]  m_out;
  logic        m_wren;

  // sampled DUT outputs of the latest step, and the bytes seen on the serial output
  logic [31:0] a_rdata;
  logic        a_stall, a_rden, a_wren;
  logic [7:0]  a_out;
  logic [7:0]  emitted[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already driven; check outputs vs model, then advance the model.
  task automatic step();
    logic        hit, full, e_stall, e_rden, do_pop;
    logic [1:0]  off;
    logic [31:0] e_rdata;
    #1;
    if (reset) begin
      q.delete();
      m_rx_full = 0; m_rx_data = 0; m_txcnt = 0; m_out = 0; m_wren = 0;
    end
    hit  = (cpu_addr[31:4] == BASE[31:4]);
    off  = cpu_addr[3:2];
    full = (q.size() == DEPTH);
    e_stall = !reset && hit && cpu_wren && off == 0 && full;
    e_rden  = !reset && serial_valid_in && !m_rx_full;
    e_rdata = 0;
    if (hit && cpu_rden) begin
      case (off)
        2'd0: e_rdata = m_rx_full ? {24'd0, m_rx_data} : 32'd0;
        2'd1: e_rdata = (q.size() << 8) | ((q.size() == 0) ? 32'd4 : 32'd0)
                        | (full ? 32'd2 : 32'd0) | (m_rx_full ? 32'd1 : 32'd0);
        2'd2: e_rdata = {16'd0, m_txcnt};
        default: e_rdata = 0;
      endcase
    end
    a_rdata = cpu_rdata; a_stall = cpu_stall; a_rden = serial_rden_out;
    a_wren  = serial_wren_out; a_out = serial_out;
    chk("cpu_stall", {31'd0, a_stall}, {31'd0, e_stall});
    chk("serial_rden_out", {31'd0, a_rden}, {31'd0, e_rden});
    chk("cpu_rdata", a_rdata, e_rdata);
    chk("serial_wren_out", {31'd0, a_wren}, {31'd0, m_wren});
    chk("serial_out", {24'd0, a_out}, {24'd0, m_out});
    if (a_wren) emitted.push_back(a_out);
    if (!reset) begin
      do_pop = (q.size() > 0) && serial_ready_in;
      if (do_pop) begin
        m_out = q.pop_front(); m_wren = 1; m_txcnt++;
      end else m_wren = 0;
      if (hit && cpu_wren && off == 0 && !full) q.push_back(cpu_wdata[7:0]);
      if (hit && cpu_rden && off == 0 && m_rx_full) m_rx_full = 0;
      else if (e_rden) begin m_rx_full = 1; m_rx_data = serial_in; end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    cpu_addr = 0; cpu_wdata = 0; cpu_wren = 0; cpu_rden = 0;
  endtask

  task automatic wr(input logic [7:0] b);
    cpu_addr = BASE; cpu_wdata = {24'hABCDE0, b}; cpu_wren = 1; cpu_rden = 0;
    step();
  endtask

  task automatic rd(input logic [1:0] off, input string nm, input logic [31:0] exp);
    cpu_addr = BASE | {28'd0, off, 2'b00}; cpu_wren = 0; cpu_rden = 1;
    step();
    chk(nm, a_rdata, exp);
    idle();
  endtask

  task automatic do_reset();
    reset = 1; idle(); step(); step(); reset = 0;
  endtask

  initial begin
    reset = 1; idle();
    serial_in = 0; serial_valid_in = 0; serial_ready_in = 0;
    @(negedge clock);
    do_reset();
    step();
    chk("idle_wren", {31'd0, a_wren}, 0);
    chk("idle_stall", {31'd0, a_stall}, 0);
    rd(2'd1, "reset_status", 32'h4);

    // two stores drain back to back, two cycles after each store
    serial_ready_in = 1; emitted.delete();
    wr(8'h48); wr(8'h69); idle();
    step(); chk("tx_H", {23'd0, a_wren, a_out}, {23'd0, 1'b1, 8'h48});
    step(); chk("tx_i", {23'd0, a_wren, a_out}, {23'd0, 1'b1, 8'h69});
    step(); chk("tx_after", {31'd0, a_wren}, 0);
    rd(2'd2, "txcount_2", 32'd2);

    // fill the FIFO with ready low, fifth store stalls until first pop
    serial_ready_in = 0; emitted.delete();
    for (int i = 0; i < 4; i++) wr(8'h10 + 8'(i));
    rd(2'd1, "status_full", 32'h402);
    wr(8'h14); chk("stall_full", {31'd0, a_stall}, 1);
    serial_ready_in = 1;
    wr(8'h14); chk("stall_same_pop", {31'd0, a_stall}, 1);
    wr(8'h14); chk("stall_drop", {31'd0, a_stall}, 0);
    idle();
    for (int i = 0; i < 8; i++) step();
    chk("order_n", emitted.size(), 5);
    for (int i = 0; i < 5 && i < emitted.size(); i++)
      chk("order_byte", {24'd0, emitted[i]}, 32'h10 + i);

    // RX capture, hold, clear, re-capture
    serial_valid_in = 1; serial_in = 8'h03;
    step(); chk("rx_rden1", {31'd0, a_rden}, 1);
    step(); chk("rx_hold", {31'd0, a_rden}, 0);
    rd(2'd1, "rx_status", 32'h5);
    rd(2'd0, "rx_data", 32'h3);
    chk("rx_no_cap_on_clear", {31'd0, a_rden}, 0);
    step(); chk("rx_rden2", {31'd0, a_rden}, 1);
    serial_valid_in = 0;
    rd(2'd0, "rx_data2", 32'h3);
    rd(2'd0, "rx_empty_read", 32'h0);

    // reset with bytes queued
    serial_ready_in = 0;
    wr(8'hA1); wr(8'hA2); wr(8'hA3); idle();
    serial_valid_in = 1;
    reset = 1; step(); serial_ready_in = 1; step(); reset = 0;
    serial_valid_in = 0; emitted.delete();
    for (int i = 0; i < 5; i++) step();
    chk("reset_no_tx", emitted.size(), 0);
    rd(2'd1, "reset_status2", 32'h4);
    rd(2'd2, "reset_txcount", 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 7);
      if (r == 0) cpu_addr = $urandom;
      else cpu_addr = BASE | {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      cpu_wdata       = $urandom;
      cpu_wren        = ($urandom_range(0, 2) == 0);
      cpu_rden        = ($urandom_range(0, 2) == 0);
      serial_in       = 8'($urandom);
      serial_valid_in = ($urandom_range(0, 1) == 0);
      serial_ready_in = ($urandom_range(0, 3) != 0);
      step();
    end

    // TXCOUNT wrap after 65537 emitted bytes
    serial_valid_in = 0;
    do_reset();
    serial_ready_in = 1;
    for (int i = 0; i < 65537; i++) wr(8'(i));
    idle();
    for (int i = 0; i < 4; i++) step();
    rd(2'd2, "txcount_wrap", 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_io_ctrl.md
# serial_io_ctrl

Memory-mapped controller that sequences the `processor` serial port on behalf of load/store instructions. It buffers outgoing bytes in a small TX FIFO and drains them under `serial_ready_in`. It captures incoming bytes into a one-entry RX holding register under `serial_valid_in`. It stalls the pipeline when a store hits a full TX FIFO.

## Interface
Parameters:
- `TX_DEPTH`, default 4: TX FIFO entries; power of two, ≥2.
- `BASE_ADDR`, default 32'hFFFF0000: base of the 16-byte register window.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cpu_addr`  in  32  byte address of the current memory access.
- `cpu_wdata`  in  32  store data.
- `cpu_wren`  in  1  store strobe.
- `cpu_rden`  in  1  load strobe.
- `cpu_rdata`  out  32  load data; combinational.
- `cpu_stall`  out  1  hold the current access; combinational.
- `serial_in`  in  8  incoming byte.
- `serial_valid_in`  in  1  `serial_in` holds a byte.
- `serial_ready_in`  in  1  sink can accept a byte.
- `serial_rden_out`  out  1  consume `serial_in` this cycle; combinational.
- `serial_out`  out  8  outgoing byte; registered.
- `serial_wren_out`  out  1  `serial_out` valid this cycle; registered, one-cycle pulse per byte.

## Operation
- **Hit decode:**
  - An access hits when `cpu_addr[31:4] == BASE_ADDR[31:4]`.
  - Register offset is `cpu_addr[3:2]`.
  - Non-hits are ignored, with `cpu_rdata` = 0 and `cpu_stall` = 0.
- **Register map:**
  - **0 DATA.**
    - Write enqueues `cpu_wdata[7:0]`.
    - Read returns {24'b0, rx_data} and clears `rx_full`.
    - Read while `rx_full`=0 returns 0 with no side effect.
  - **1 STATUS** (read-only):
    - bit0 `rx_full`; bit1 tx_full; bit2 tx_empty.
    - bits[10:8] tx_count, zero-extended as needed for `TX_DEPTH`.
  - **2 TXCOUNT** (read-only): 16-bit count of bytes emitted on `serial_wren_out`; wraps 0xFFFF→0.
  - **3:** reads 0, writes ignored.
  - Writes to STATUS and TXCOUNT are ignored.
- **TX path:**
  - `cpu_stall` = hit & `cpu_wren` & offset 0 & tx_full.
  - Full is evaluated on the pre-edge count. A store hitting a full FIFO stalls even if a pop occurs the same cycle; it enqueues the following cycle.
  - Pop condition each edge: FIFO non-empty & `serial_ready_in`.
  - On pop: `serial_out` <= head byte and `serial_wren_out` <= 1; otherwise `serial_wren_out` <= 0 and `serial_out` holds.
  - Simultaneous enqueue and pop on a non-full FIFO leaves the count unchanged.
  - Byte order is strictly FIFO. Pointers wrap modulo `TX_DEPTH`.
- **RX path:**
  - `serial_rden_out` = `serial_valid_in` & !`rx_full`.
  - On that edge: `rx_data` <= `serial_in` and `rx_full` <= 1.
  - A DATA read clearing `rx_full` does not allow capture in the same cycle; the next capture happens at the following edge at the earliest.
  - A byte is never overwritten while `rx_full`=1.
- **Reset:**
  - Reset mid-operation discards FIFO contents and any held RX byte.
  - TX pointers, count, `rx_full`, `rx_data`, TXCOUNT, `serial_out` and `serial_wren_out` all clear to 0.

## Timing
- Store accepted at edge E → earliest `serial_wren_out`=1 during cycle after edge E+1 (2-cycle latency) if `serial_ready_in` is held.
- Sustained throughput: one byte per cycle while `serial_ready_in`=1.
- `serial_ready_in` low holds the FIFO. `serial_wren_out` drops at the next edge.
- Load data is combinational in the access cycle. The DATA-read side effect happens at the end of that cycle.
- RX capture: valid at cycle C with empty holder → `rx_full`=1 from C+1.
- `cpu_stall` and `serial_rden_out` are 0 while `reset` is high.

## Structure
- Package `serial_io_pkg`:
  - register offset constants (DATA=0, STATUS=1, TXCOUNT=2);
  - STATUS bit positions;
  - TXCOUNT width (16).
- Sub-module `serial_tx_fifo`: parameterised by `TX_DEPTH`; push/pop/full/empty/count, asynchronous reset.
- Decode, RX holder and TXCOUNT live in the top.

## Test plan
- Reset release, idle: all outputs 0; STATUS read = 0x00000004.
- Store 0x48, 0x69 to DATA with `serial_ready_in`=1 → `serial_wren_out` pulses carrying 'H' then 'i' on consecutive cycles, 2 cycles after each store; TXCOUNT reads 2.
- `serial_ready_in`=0, five stores with `TX_DEPTH`=4 → fifth store sees `cpu_stall`=1; STATUS bit1=1, tx_count=4. Raise ready → stall drops after first pop; bytes emerge in order.
- `serial_valid_in`=1, `serial_in`=0x03 → `serial_rden_out` one cycle, STATUS bit0=1. DATA read returns 0x00000003, then `rden` again after clear.
- Reset asserted with 3 bytes queued → no further `serial_wren_out`; after release STATUS = 0x00000004 and TXCOUNT = 0.
- 65536+1 bytes emitted → TXCOUNT reads 1 (wrap).
